demux_sched: RTL and testbench

Round-robin/directed scheduler that sequences the 1-to-4 demux lanes of the datapath. It takes a valid/ready input stream, picks the destination lane each cycle, drives the demux select, and holds one word per lane in an output register until that lane's consumer accepts it. An enable/drain state machine lets the stream be stopped cleanly, with all pending lane data delivered before the block goes idle.

---
 rtl/demux_pkg.sv | 18 +
 rtl/lane_reg.sv | 42 ++++
 rtl/demux_sched.sv | 133 +++++++++++++
 tb/tb_demux_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared types and sizing constants for the demux lane scheduler.
//   state_e  - scheduler FSM state (IDLE, RUN, DRAIN)
//   N_LANES  - number of demux output lanes
//   SEL_W    - width of the lane select
//   CNT_W    - width of the delivered-word counter
package demux_pkg;

    localparam int N_LANES = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/lane_reg.sv
// lane_reg: one-entry output register for a single demux lane.
//   clk, rst_n  - clock, synchronous active-low reset
//   load_i      - capture data_i this cycle
//   data_i      - word to capture
//   ready_i     - consumer takes the held word this cycle
//   data_o      - held word
//   valid_o     - register holds a word
module lane_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load in the same cycle as a drain wins: the slot refills with new data.
    always_comb begin
        data_d  = load_i ? data_i : data_q;
        valid_d = load_i | (valid_q & ~ready_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_sched.sv
// demux_sched: round-robin / directed scheduler for a 1-to-4 demux.
//   clk, rst_n        - clock, synchronous active-low reset
//   en                - run enable; deassert to drain and stop
//   mode              - 0 round-robin, 1 directed by d_dest
//   lane_en[3:0]      - per-lane enable mask
//   d_in, d_dest      - input word and its directed destination
//   d_in_valid/ready  - input handshake
//   d_sel[1:0]        - demux select (current target lane)
//   d_out_0..3        - lane output registers
//   d_out_valid[3:0]  - lane holds a word; d_out_ready[3:0] consumer takes it
//   drop              - pulse: directed word to a disabled lane was discarded
//   xfer_cnt[7:0]     - words delivered into lane registers (wraps)
//   busy              - scheduler is not idle
module demux_sched
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N_LANES-1:0] lane_en,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [SEL_W-1:0]   d_dest,
    input  logic               d_in_valid,
    output logic               d_in_ready,
    output logic [SEL_W-1:0]   d_sel,
    output logic [WIDTH-1:0]   d_out_0,
    output logic [WIDTH-1:0]   d_out_1,
    output logic [WIDTH-1:0]   d_out_2,
    output logic [WIDTH-1:0]   d_out_3,
    output logic [N_LANES-1:0] d_out_valid,
    input  logic [N_LANES-1:0] d_out_ready,
    output logic               drop,
    output logic [CNT_W-1:0]   xfer_cnt,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEL_W-1:0]   rr_lane, tgt;
    logic               rr_hit, is_drop, lane_free, accept, do_load;
    logic [N_LANES-1:0] load_vec;
    logic [WIDTH-1:0]   lane_data [N_LANES];

    // Round-robin search: scanning from the far end toward ptr lets the
    // lowest offset from ptr overwrite, giving first-enabled-at-or-after-ptr.
    always_comb begin
        rr_hit  = 1'b0;
        rr_lane = ptr_q;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (lane_en[ptr_q + SEL_W'(i)]) begin
                rr_hit  = 1'b1;
                rr_lane = ptr_q + SEL_W'(i);
            end
        end
    end

    // Ready is built only from registered state and sideband inputs, never
    // from d_in_valid, so upstream can safely wait on it.
    always_comb begin
        tgt        = mode ? d_dest : rr_lane;
        is_drop    = mode & ~lane_en[d_dest];
        lane_free  = ~d_out_valid[tgt] | d_out_ready[tgt];
        d_in_ready = (state_q == RUN) & (is_drop | ((mode | rr_hit) & lane_free));
        accept     = d_in_ready & d_in_valid;
        do_load    = accept & ~is_drop;
    end

    assign d_sel = tgt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            // Completion of the drain takes priority over a returning enable.
            DRAIN:   if (d_out_valid == '0) state_d = IDLE;
                     else if (en) state_d = RUN;
            default: state_d = IDLE;
        endcase

        ptr_d = ptr_q;
        if (do_load && !mode) ptr_d = tgt + 1'b1;
        if (state_q != IDLE && state_d == IDLE) ptr_d = '0;

        cnt_d  = do_load ? cnt_q + 1'b1 : cnt_q;
        drop_d = accept & is_drop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign load_vec[gi] = do_load & (tgt == SEL_W'(gi));
            lane_reg #(.WIDTH(WIDTH)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (load_vec[gi]),
                .data_i  (d_in),
                .ready_i (d_out_ready[gi]),
                .data_o  (lane_data[gi]),
                .valid_o (d_out_valid[gi])
            );
        end
    endgenerate

    assign d_out_0  = lane_data[0];
    assign d_out_1  = lane_data[1];
    assign d_out_2  = lane_data[2];
    assign d_out_3  = lane_data[3];
    assign drop     = drop_q;
    assign xfer_cnt = cnt_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: randomized stimulus against a queue-based reference model.
// The driver predicts the target lane, ready, counters and state each cycle and
// pushes every delivered word onto that lane's expected queue; an independent
// monitor pops and compares whenever a lane hands a word to its consumer.
module tb_demux_sched;

    localparam int W = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, mode, d_in_valid;
    logic [3:0]   lane_en, d_out_ready;
    logic [W-1:0] d_in;
    logic [1:0]   d_dest;
    logic         d_in_ready, drop, busy;
    logic [1:0]   d_sel;
    logic [W-1:0] d_out_0, d_out_1, d_out_2, d_out_3;
    logic [3:0]   d_out_valid;
    logic [7:0]   xfer_cnt;
    logic [W-1:0] dout [4];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] lane_q [4][$];
    int           m_state = 0;   // 0 idle, 1 run, 2 drain
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    bit           m_drop  = 0;

    always #5 clk = ~clk;

    demux_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .lane_en(lane_en),
        .d_in(d_in), .d_dest(d_dest), .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
        .d_sel(d_sel), .d_out_0(d_out_0), .d_out_1(d_out_1), .d_out_2(d_out_2),
        .d_out_3(d_out_3), .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
        .drop(drop), .xfer_cnt(xfer_cnt), .busy(busy)
    );

    assign dout[0] = d_out_0;
    assign dout[1] = d_out_1;
    assign dout[2] = d_out_2;
    assign dout[3] = d_out_3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict and compare mid-cycle,
    // then advance the model at the rising edge.
    task automatic step(input logic e, input logic m, input logic [3:0] le,
                        input logic [1:0] dst, input logic v, input logic [3:0] ordy,
                        input logic rn = 1'b1);
        int  t, idx, ns;
        bit  any, drop_c, free, exp_rdy, acc, all_empty;
        logic [W-1:0] word;
        @(negedge clk);
        rst_n = rn; en = e; mode = m; lane_en = le; d_dest = dst;
        d_in_valid = v; d_out_ready = ordy; d_in = W'($urandom);
        word = d_in;
        #1;
        any = 0;
        t   = m_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = (m_ptr + i) % 4;
            if (!any && le[idx]) begin
                any = 1;
                t   = idx;
            end
        end
        if (m) t = dst;
        drop_c  = m && !le[dst];
        free    = (lane_q[t].size() == 0) || ordy[t];
        exp_rdy = (m_state == 1) && (drop_c || ((m || any) && free));
        acc     = exp_rdy && v;
        all_empty = 1;
        for (int k = 0; k < 4; k++) if (lane_q[k].size() != 0) all_empty = 0;

        check("d_sel", d_sel, t);
        check("d_in_ready", d_in_ready, exp_rdy);
        check("busy", busy, m_state != 0);
        check("drop", drop, m_drop);
        check("xfer_cnt", xfer_cnt, m_cnt);

        case (m_state)
            0:       ns = e ? 1 : 0;
            1:       ns = e ? 1 : 2;
            default: ns = all_empty ? 0 : (e ? 1 : 2);
        endcase

        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < 4; k++) lane_q[k].delete();
            m_state = 0; m_ptr = 0; m_cnt = 0; m_drop = 0;
        end else begin
            m_drop = acc && drop_c;
            if (acc && !drop_c) begin
                lane_q[t].push_back(word);
                m_cnt = (m_cnt + 1) % 256;
                if (!m) m_ptr = (t + 1) % 4;
                $display("accept lane %0d data %0d cnt %0d", t, word, m_cnt);
            end else if (acc) begin
                $display("accept dropped dest %0d", dst);
            end
            if (ns == 0 && m_state != 0) m_ptr = 0;
            m_state = ns;
        end
    endtask

    // Monitor: every lane handing a word to its consumer must match the head
    // of that lane's expected queue.
    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        #2;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                check("d_out_valid", d_out_valid[k], lane_q[k].size() != 0);
                if (d_out_valid[k] && d_out_ready[k] && lane_q[k].size() != 0) begin
                    exp_w = lane_q[k].pop_front();
                    check("d_out_data", dout[k], exp_w);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 0; mode = 0; lane_en = 4'hF; d_dest = 0;
        d_in_valid = 0; d_out_ready = 4'h0; d_in = '0;
        repeat (2) @(posedge clk);

        // Reset state
        step(0, 0, 4'hF, 0, 0, 4'hF);

        // Round-robin, all lanes enabled and draining
        repeat (10) step(1, 0, 4'hF, 0, 1, 4'hF);
        // Only lanes 1 and 3 enabled
        repeat (6) step(1, 0, 4'b1010, 0, 1, 4'hF);
        // Lane 2 consumer stalls, then releases
        repeat (8) step(1, 0, 4'hF, 0, 1, 4'b1011);
        repeat (4) step(1, 0, 4'hF, 0, 1, 4'hF);
        // Directed to a disabled lane (drop), then to lane 1
        repeat (2) step(1, 1, 4'b1011, 2, 1, 4'hF);
        repeat (2) step(1, 1, 4'b1011, 1, 1, 4'hF);
        // Fill every lane, drop enable, release lanes one at a time
        repeat (6) step(1, 0, 4'hF, 0, 1, 4'h0);
        repeat (3) step(0, 0, 4'hF, 0, 1, 4'h0);
        step(0, 0, 4'hF, 0, 1, 4'b0001);
        step(0, 0, 4'hF, 0, 1, 4'b0010);
        step(0, 0, 4'hF, 0, 1, 4'b0100);
        step(0, 0, 4'hF, 0, 1, 4'b1000);
        repeat (3) step(0, 0, 4'hF, 0, 1, 4'h0);
        repeat (4) step(1, 0, 4'hF, 0, 1, 4'hF);
        // Reset with three lanes full
        repeat (4) step(1, 0, 4'b0111, 0, 1, 4'h0);
        step(1, 0, 4'b0111, 0, 1, 4'h0, 1'b0);
        repeat (3) step(1, 0, 4'hF, 0, 0, 4'h0);

        // Free-running random traffic
        repeat (400)
            step($urandom_range(7, 0) != 0, $urandom_range(3, 0) == 0,
                 4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
                 $urandom_range(99, 0) != 0);

        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
